// File: rtl/iob_cache_fe_arbiter.sv
// Shares one iob_cache native front-end port between an instruction (read-only) and a data requester.
// Define IOB_CACHE_ARB_RR_EN for round-robin arbitration; the default build uses fixed D-over-I priority.
module iob_cache_fe_arbiter #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      i_valid,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]  i_addr,
    output logic [FE_DATA_W-1:0]                      i_rdata,
    output logic                                      i_ready,
    input  logic                                      d_valid,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]  d_addr,
    input  logic [FE_DATA_W-1:0]                      d_wdata,
    input  logic [FE_DATA_W/8-1:0]                    d_wstrb,
    output logic [FE_DATA_W-1:0]                      d_rdata,
    output logic                                      d_ready,
    output logic                                      m_valid,
    output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]  m_addr,
    output logic [FE_DATA_W-1:0]                      m_wdata,
    output logic [FE_DATA_W/8-1:0]                    m_wstrb,
    input  logic [FE_DATA_W-1:0]                      m_rdata,
    input  logic                                      m_ready
);
    localparam int NB   = FE_DATA_W / 8;
    localparam int WA_W = FE_ADDR_W - $clog2(NB);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state;
    logic              r_gnt;
    logic [WA_W-1:0]   r_req_addr;
    logic [FE_DATA_W-1:0] r_req_wdata;
    logic [NB-1:0]     r_req_wstrb;
    logic              w_pick_d;
    logic              w_busy;

`ifdef IOB_CACHE_ARB_RR_EN
    logic              r_last;

    // On a tie, serve whoever was not served last (r_last: 0 = I, 1 = D).
    assign w_pick_d = d_valid & (~i_valid | ~r_last);
`else
    assign w_pick_d = d_valid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
`ifdef IOB_CACHE_ARB_RR_EN
            r_last      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid | d_valid) begin
                        r_state <= BUSY;
                        r_gnt   <= w_pick_d;
                        if (w_pick_d) begin
                            r_req_addr  <= d_addr;
                            r_req_wdata <= d_wdata;
                            r_req_wstrb <= d_wstrb;
                        end else begin
                            r_req_addr  <= i_addr;
                            r_req_wdata <= '0;
                            r_req_wstrb <= '0;
                        end
                    end
                end
                BUSY: begin
                    // The latched request stays on the cache port until the cache accepts it.
                    if (m_ready) begin
                        r_state <= IDLE;
`ifdef IOB_CACHE_ARB_RR_EN
                        r_last  <= r_gnt;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_busy  = (r_state == BUSY);
    assign m_valid = w_busy;
    assign m_addr  = r_req_addr;
    assign m_wdata = r_req_wdata;
    assign m_wstrb = r_req_wstrb;

    assign i_ready = w_busy & m_ready & ~r_gnt;
    assign d_ready = w_busy & m_ready & r_gnt;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Self-checking bench for iob_cache_fe_arbiter: directed scenarios plus a randomized run against
// a transaction-level model with a behavioural cache memory behind the m_* port.
module tb_iob_cache_fe_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [29:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_valid;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_valid;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] cmem [64] = '{default: 32'h0};
    logic [31:0] smem [64] = '{default: 32'h0};

    always #5 clk = ~clk;

    iob_cache_fe_arbiter #(.FE_ADDR_W(32), .FE_DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    // Behavioural cache: read data is the stored word, writes land on the accepting edge.
    assign m_rdata = cmem[m_addr[5:0]];
    always @(posedge clk) begin
        if (m_valid && m_ready)
            for (int b = 0; b < 4; b++)
                if (m_wstrb[b]) cmem[m_addr[5:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0; m_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b exp 0", m_valid); end
        checks++; if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", {i_ready, d_ready}); end
        checks++; if ({m_addr, m_wdata, m_wstrb} !== 66'h0) begin errors++; $display("FAIL reset_req_regs: got %h/%h/%h exp 0", m_addr, m_wdata, m_wstrb); end
        tick();
        reset = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_d_write();
        tick();
        d_valid = 1'b1; d_addr = 30'h10; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL dwr_cycle0_m_valid: got %b exp 0", m_valid); end
        tick();
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL dwr_m_valid: got %b exp 1", m_valid); end
        checks++; if ({m_addr, m_wdata, m_wstrb} !== {30'h10, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL dwr_m_fields: got %h/%h/%h exp 10/deadbeef/f", m_addr, m_wdata, m_wstrb); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL dwr_early_ready: got %b exp 0", d_ready); end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b01) begin errors++; $display("FAIL dwr_ready: got %b exp 01", {i_ready, d_ready}); end
        smem[16] = merge(smem[16], 32'hDEADBEEF, 4'hF);
        tick();
        d_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL dwr_back_idle: got %b exp 0", m_valid); end
    endtask

    task automatic test_i_read();
        tick();
        i_valid = 1'b1; i_addr = 30'h10;
        tick();
        @(negedge clk);
        checks++; if ({m_valid, m_addr, m_wstrb, m_wdata} !== {1'b1, 30'h10, 4'h0, 32'h0}) begin errors++; $display("FAIL ird_m_fields: got %b/%h/%h/%h exp 1/10/0/0", m_valid, m_addr, m_wstrb, m_wdata); end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b10) begin errors++; $display("FAIL ird_ready: got %b exp 10", {i_ready, d_ready}); end
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ird_rdata: got %h exp deadbeef", i_rdata); end
        tick();
        i_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        logic exp_d;
        tick();
        i_valid = 1'b1; i_addr = 30'h11; d_valid = 1'b1; d_addr = 30'h10; d_wstrb = 4'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef IOB_CACHE_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            m_ready = 1'b1;
            @(negedge clk);
            checks++; if ({i_ready, d_ready} !== {~exp_d, exp_d}) begin errors++; $display("FAIL sim_grant_%0d: got %b exp %b", k, {i_ready, d_ready}, {~exp_d, exp_d}); end
            checks++; if (m_rdata !== smem[exp_d ? 16 : 17]) begin errors++; $display("FAIL sim_rdata_%0d: got %h exp %h", k, m_rdata, smem[exp_d ? 16 : 17]); end
            tick();
            m_ready = 1'b0;
        end
        i_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = $urandom;
        tick();
        d_valid = 1'b1; d_addr = 30'h21; d_wdata = w; d_wstrb = 4'h3; i_valid = 1'b0; i_addr = 30'h5;
        tick();
        for (int k = 0; k < 10; k++) begin
            i_valid = k[0];
            @(negedge clk);
            checks++; if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 30'h21, w, 4'h3}) begin errors++; $display("FAIL stall_hold_%0d: got %b/%h/%h/%h exp 1/21/%h/3", k, m_valid, m_addr, m_wdata, m_wstrb, w); end
            checks++; if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready_%0d: got %b exp 00", k, {i_ready, d_ready}); end
            tick();
        end
        i_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b01) begin errors++; $display("FAIL stall_done: got %b exp 01", {i_ready, d_ready}); end
        smem[33] = merge(smem[33], w, 4'h3);
        tick();
        d_valid = 1'b0; d_wstrb = 4'h0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        tick();
        d_valid = 1'b1; d_addr = 30'h21; d_wstrb = 4'h0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({m_valid, i_ready, d_ready} !== 3'b100) begin errors++; $display("FAIL rstb_third_busy: got %b exp 100", {m_valid, i_ready, d_ready}); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({m_valid, i_ready, d_ready} !== 3'b000) begin errors++; $display("FAIL rstb_aborted: got %b exp 000", {m_valid, i_ready, d_ready}); end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if ({m_valid, m_addr, d_ready} !== {1'b1, 30'h21, 1'b1}) begin errors++; $display("FAIL rstb_regrant: got %b/%h/%b exp 1/21/1", m_valid, m_addr, d_ready); end
        checks++; if (d_rdata !== smem[33]) begin errors++; $display("FAIL rstb_rdata: got %h exp %h", d_rdata, smem[33]); end
        tick();
        d_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_ready();
        tick();
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if ({m_valid, i_ready, d_ready} !== 3'b000) begin errors++; $display("FAIL stray_idle: got %b exp 000", {m_valid, i_ready, d_ready}); end
            tick();
        end
        d_valid = 1'b1; d_addr = 30'h10; d_wstrb = 4'h0;
        @(negedge clk);
        checks++; if ({m_valid, d_ready} !== 2'b00) begin errors++; $display("FAIL stray_req_cycle0: got %b exp 00", {m_valid, d_ready}); end
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        checks++; if ({m_valid, d_ready} !== 2'b11) begin errors++; $display("FAIL stray_req_done: got %b exp 11", {m_valid, d_ready}); end
        tick();
        m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit mbusy, mwho, i_act, d_act, pick_d, exp_i, exp_d;
        logic [29:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwstrb;
`ifdef IOB_CACHE_ARB_RR_EN
        bit mlast;
        mlast = 1'b0;
`endif
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mbusy = 1'b0; mwho = 1'b0; i_act = 1'b0; d_act = 1'b0;
        maddr = '0; mwdata = '0; mwstrb = '0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (!i_act && ($urandom % 3 == 0)) begin
                i_act = 1'b1; i_addr = 30'($urandom_range(0, 63));
            end
            i_valid = i_act;
            if (!d_act && ($urandom % 3 == 0)) begin
                d_act = 1'b1; d_addr = 30'($urandom_range(0, 63)); d_wdata = $urandom;
                d_wstrb = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
            end
            d_valid = d_act;
            m_ready = ($urandom % 3 == 0);
            @(negedge clk);
            exp_i = mbusy && m_ready && !mwho;
            exp_d = mbusy && m_ready && mwho;
            checks++; if (m_valid !== mbusy) begin errors++; $display("FAIL rnd_m_valid c%0d: got %b exp %b", c, m_valid, mbusy); end
            if (mbusy) begin
                checks++; if ({m_addr, m_wdata, m_wstrb} !== {maddr, mwdata, mwstrb}) begin errors++; $display("FAIL rnd_m_fields c%0d: got %h/%h/%h exp %h/%h/%h", c, m_addr, m_wdata, m_wstrb, maddr, mwdata, mwstrb); end
            end
            checks++; if ({i_ready, d_ready} !== {exp_i, exp_d}) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, {i_ready, d_ready}, {exp_i, exp_d}); end
            checks++; if (i_ready && d_ready) begin errors++; $display("FAIL rnd_both_ready c%0d: got 11 exp not both", c); end
            if (exp_i) begin
                checks++; if (i_rdata !== smem[maddr[5:0]]) begin errors++; $display("FAIL rnd_i_rdata c%0d: got %h exp %h", c, i_rdata, smem[maddr[5:0]]); end
            end
            if (exp_d && mwstrb == 4'h0) begin
                checks++; if (d_rdata !== smem[maddr[5:0]]) begin errors++; $display("FAIL rnd_d_rdata c%0d: got %h exp %h", c, d_rdata, smem[maddr[5:0]]); end
            end
            // Advance the transaction-level model to the next cycle.
            if (mbusy) begin
                if (m_ready) begin
                    mbusy = 1'b0;
                    if (mwho) begin
                        d_act = 1'b0;
                        smem[maddr[5:0]] = merge(smem[maddr[5:0]], mwdata, mwstrb);
                    end else begin
                        i_act = 1'b0;
                    end
`ifdef IOB_CACHE_ARB_RR_EN
                    mlast = mwho;
`endif
                end
            end else if (i_act || d_act) begin
`ifdef IOB_CACHE_ARB_RR_EN
                pick_d = d_act && !(i_act && mlast);
`else
                pick_d = d_act;
`endif
                mbusy = 1'b1; mwho = pick_d;
                maddr  = pick_d ? d_addr : i_addr;
                mwdata = pick_d ? d_wdata : 32'h0;
                mwstrb = pick_d ? d_wstrb : 4'h0;
            end
        end
        tick();
        i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_d_write();
        test_i_read();
        test_simultaneous();
        test_stall();
        test_reset_mid_busy();
        test_stray_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
